// File: rtl/bmult_share_arbiter.sv
// Round-robin sharing of a single WIDTH x WIDTH multiplier between N_REQ requesters.
// Granted operands are registered onto the multiplier; a tag pipe routes each product back.
module bmult_share_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [2*WIDTH-1:0]     resp_p,
  output logic [WIDTH-1:0]       mult_A,
  output logic [WIDTH-1:0]       mult_B,
  input  logic [2*WIDTH-1:0]     mult_P,
  output logic                   idle
);

  localparam int unsigned TW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Entry 0 travels alongside the operand register; MULT_LAT more entries cover the multiplier.
  localparam int unsigned DEPTH = MULT_LAT + 1;

  logic [TW-1:0]    rr_ptr;
  logic [TW-1:0]    sel;
  logic             found;
  logic             accept;
  logic [DEPTH-1:0] tag_valid;
  logic [TW-1:0]    tag_id [DEPTH];
  int unsigned      pos;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    pos   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (32'(rr_ptr) + k) % N_REQ;
      if (!found && req_valid[TW'(pos)]) begin
        found = 1'b1;
        sel   = TW'(pos);
      end
    end
  end

  assign accept    = found && en && !rst;
  assign req_ready = accept ? (N_REQ'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      mult_A    <= '0;
      mult_B    <= '0;
      rr_ptr    <= '0;
      tag_valid <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      if (accept) begin
        mult_A <= req_a[32'(sel)*WIDTH +: WIDTH];
        mult_B <= req_b[32'(sel)*WIDTH +: WIDTH];
        rr_ptr <= (sel == TW'(N_REQ - 1)) ? '0 : sel + TW'(1);
      end
      tag_valid[0] <= accept;
      tag_id[0]    <= sel;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  // The oldest tag owns whatever the multiplier presents this cycle.
  assign resp_valid = tag_valid[DEPTH-1] ? (N_REQ'(1) << tag_id[DEPTH-1]) : '0;
  assign resp_p     = tag_valid[DEPTH-1] ? mult_P : '0;
  assign idle       = ~|req_ready & ~|tag_valid;

endmodule

// File: tb/tb_bmult_share_arbiter.sv
// Directed table plus hand sequences and a random scoreboard run for bmult_share_arbiter
// with a one-stage multiplier model.
module tb_bmult_share_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   resp_valid;
  logic [2*W-1:0] resp_p;
  logic [W-1:0]   mult_A;
  logic [W-1:0]   mult_B;
  logic [2*W-1:0] mult_P = '0;
  logic           idle;

  int checks   = 0;
  int failures = 0;

  bmult_share_arbiter #(.N_REQ(N), .WIDTH(W), .MULT_LAT(1)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_p(resp_p),
    .mult_A(mult_A), .mult_B(mult_B), .mult_P(mult_P),
    .idle(idle)
  );

  always #5 clk = ~clk;

  // One-stage multiplier model
  always @(posedge clk) mult_P <= 64'(mult_A) * 64'(mult_B);

  typedef struct {
    logic        en;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [3:0]  rv;
    logic [63:0] p;
    logic        idle;
  } vec_t;

  vec_t tbl[14];
  logic [31:0] opa[N];
  logic [31:0] opb[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
  endtask

  task automatic drive(input logic e, input logic [3:0] v);
    @(posedge clk);
    #1;
    en        = e;
    req_valid = v;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [3:0] rdy, input logic [3:0] rv,
                            input logic [63:0] p);
    chk({name, ".ready"}, 64'(req_ready), 64'(rdy));
    chk({name, ".resp_valid"}, 64'(resp_valid), 64'(rv));
    chk({name, ".resp_p"}, resp_p, p);
  endtask

  // Random-phase model state
  int          m_rr;
  int          g;
  int          accepts;
  int          cyc;
  logic [3:0]  exp_rdy;
  logic        pv1, pv2;
  int          pi1, pi2;
  logic [63:0] pp1, pp2;

  initial begin
    opa[0] = 32'h0000_0003; opb[0] = 32'h0000_0005;
    opa[1] = 32'h0000_0010; opb[1] = 32'h0000_0020;
    opa[2] = 32'hFFFF_FFFF; opb[2] = 32'hFFFF_FFFF;
    opa[3] = 32'h1234_5678; opb[3] = 32'h0000_0010;
    pack_ops();

    //               en    valid    ready    rv       p                        idle
    tbl[0]  = '{1'b1, 4'b0001, 4'b0001, 4'b0000, 64'h0,                   1'b0};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 64'h0,                   1'b0};
    tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 64'hF,                   1'b0};
    tbl[3]  = '{1'b1, 4'b1111, 4'b0010, 4'b0000, 64'h0,                   1'b0};
    tbl[4]  = '{1'b1, 4'b1111, 4'b0100, 4'b0000, 64'h0,                   1'b0};
    tbl[5]  = '{1'b1, 4'b1111, 4'b1000, 4'b0010, 64'h200,                 1'b0};
    tbl[6]  = '{1'b1, 4'b1111, 4'b0001, 4'b0100, 64'hFFFF_FFFE_0000_0001, 1'b0};
    tbl[7]  = '{1'b1, 4'b1111, 4'b0010, 4'b1000, 64'h1_2345_6780,         1'b0};
    tbl[8]  = '{1'b1, 4'b1111, 4'b0100, 4'b0001, 64'hF,                   1'b0};
    tbl[9]  = '{1'b1, 4'b1111, 4'b1000, 4'b0010, 64'h200,                 1'b0};
    tbl[10] = '{1'b1, 4'b0000, 4'b0000, 4'b0100, 64'hFFFF_FFFE_0000_0001, 1'b0};
    tbl[11] = '{1'b1, 4'b0000, 4'b0000, 4'b1000, 64'h1_2345_6780,         1'b0};
    tbl[12] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 64'h0,                   1'b1};
    tbl[13] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 64'h0,                   1'b1};

    // Reset with every requester asserting: nothing may be granted
    rst = 1'b1; en = 1'b1; req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_out("reset", 4'b0000, 4'b0000, 64'h0);
    chk("reset.idle", 64'(idle), 64'd1);
    chk("reset.mult_A", 64'(mult_A), 64'h0);
    chk("reset.mult_B", 64'(mult_B), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = '0;

    // Single op, full rotation, drain, en=0 gating
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].valid);
      expect_out($sformatf("tbl%0d", i), tbl[i].ready, tbl[i].rv, tbl[i].p);
      chk($sformatf("tbl%0d.idle", i), 64'(idle), 64'(tbl[i].idle));
    end

    // Wrap from rr_ptr=3 to req0, then req1 ahead of req3
    drive(1'b1, 4'b0100); expect_out("wrap.a", 4'b0100, 4'b0000, 64'h0);
    drive(1'b1, 4'b0001); expect_out("wrap.b", 4'b0001, 4'b0000, 64'h0);
    drive(1'b1, 4'b1010); expect_out("wrap.c", 4'b0010, 4'b0100, 64'hFFFF_FFFE_0000_0001);
    drive(1'b1, 4'b1000); expect_out("wrap.d", 4'b1000, 4'b0001, 64'hF);
    drive(1'b1, 4'b0000); expect_out("wrap.e", 4'b0000, 4'b0010, 64'h200);
    drive(1'b1, 4'b0000); expect_out("wrap.f", 4'b0000, 4'b1000, 64'h1_2345_6780);
    drive(1'b1, 4'b0000); chk("wrap.idle", 64'(idle), 64'd1);

    // en falls with two ops in flight
    drive(1'b1, 4'b0011); expect_out("en.a", 4'b0001, 4'b0000, 64'h0);
    drive(1'b1, 4'b0010); expect_out("en.b", 4'b0010, 4'b0000, 64'h0);
    drive(1'b0, 4'b1111); expect_out("en.c", 4'b0000, 4'b0001, 64'hF);
    chk("en.c.idle", 64'(idle), 64'd0);
    drive(1'b0, 4'b1111); expect_out("en.d", 4'b0000, 4'b0010, 64'h200);
    chk("en.d.idle", 64'(idle), 64'd0);
    drive(1'b0, 4'b1111); expect_out("en.e", 4'b0000, 4'b0000, 64'h0);
    chk("en.e.idle", 64'(idle), 64'd1);

    // rst one cycle after accepting req2 discards it; grants restart at req0
    drive(1'b1, 4'b0100); expect_out("rst.a", 4'b0100, 4'b0000, 64'h0);
    @(posedge clk); #1; rst = 1'b1; req_valid = 4'b1111; @(negedge clk);
    chk("rst.b.ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1; rst = 1'b0; @(negedge clk);
    expect_out("rst.c", 4'b0001, 4'b0000, 64'h0);
    chk("rst.c.mult_A", 64'(mult_A), 64'h0);
    drive(1'b1, 4'b0000); expect_out("rst.d", 4'b0000, 4'b0000, 64'h0);
    drive(1'b1, 4'b0000); expect_out("rst.e", 4'b0000, 4'b0001, 64'hF);

    // Random run against an arbitration/latency model
    @(posedge clk); #1; rst = 1'b1; req_valid = '0;
    @(posedge clk); #1; rst = 1'b0;
    m_rr = 0; pv1 = 1'b0; pv2 = 1'b0; pi1 = 0; pi2 = 0; pp1 = '0; pp2 = '0;
    accepts = 0; cyc = 0;
    while (accepts < 20000 && cyc < 40000) begin
      @(posedge clk);
      #1;
      cyc++;
      req_valid = 4'($urandom);
      en        = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        opa[i] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
        opb[i] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      pack_ops();
      g = -1;
      if (en) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
      end
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      @(negedge clk);
      chk("rnd.ready", 64'(req_ready), 64'(exp_rdy));
      chk("rnd.resp_valid", 64'(resp_valid), pv2 ? 64'(4'b0001 << pi2) : 64'h0);
      chk("rnd.resp_p", resp_p, pv2 ? pp2 : 64'h0);
      pv2 = pv1; pi2 = pi1; pp2 = pp1;
      pv1 = (g >= 0);
      if (g >= 0) begin
        pi1 = g;
        pp1 = 64'(opa[g]) * 64'(opb[g]);
        m_rr = (g + 1) % N;
        accepts++;
      end
    end
    chk("rnd.accept_budget", 64'(accepts >= 20000), 64'd1);
    for (int d = 0; d < 3; d++) begin
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      chk("drain.resp_valid", 64'(resp_valid), pv2 ? 64'(4'b0001 << pi2) : 64'h0);
      chk("drain.resp_p", resp_p, pv2 ? pp2 : 64'h0);
      pv2 = pv1; pi2 = pi1; pp2 = pp1; pv1 = 1'b0;
    end
    chk("drain.idle", 64'(idle), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
